game_score_timer: RTL

Upstream feeder for the eight-digit seven-segment driver. It keeps the game's elapsed time (MM:SS) and score as BCD digits, advanced by the driver's 1 Hz `div_clk` output. It runs the game-phase state machine (idle/run/pause/over) and presents eight 4-bit digits directly on the driver's `dig7..dig0` inputs.

---
 rtl/game_disp_pkg.sv | 22 ++
 rtl/bcd_sat_add4.sv | 44 ++++
 rtl/game_score_timer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/game_disp_pkg.sv
`default_nettype none
// =====================================================================
// game_disp_pkg : phase encoding and BCD widths for the score/timer feeder
// Rev 1.0
// =====================================================================
package game_disp_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] OVER  = 2'd3;

   localparam int BCD_W  = 4;
   localparam int BCD4_W = 4 * BCD_W;

   // Two-digit BCD of a 0..99 integer, used for elaboration-time limits.
   function automatic logic [2*BCD_W-1:0] dec2bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_sat_add4.sv
`default_nettype none
// =====================================================================
// bcd_sat_add4 : four-digit BCD plus a 0..10 addend, saturating at 9999
// Rev 1.0
// =====================================================================
module bcd_sat_add4
   import game_disp_pkg::*;
(
   input  logic [BCD4_W-1:0] i_a,
   input  logic [BCD_W-1:0]  i_b,
   output logic [BCD4_W-1:0] o_sum
);

   logic [BCD4_W-1:0] w_raw;
   logic [4:0]        w_dsum;
   logic [4:0]        w_adj;
   logic              w_carry;

   // Addend enters the units digit only; a carry out of the top digit means overflow.
   always_comb begin
      w_raw   = '0;
      w_carry = 1'b0;
      w_dsum  = '0;
      w_adj   = '0;
      for (int i = 0; i < 4; i++) begin
         w_dsum = {1'b0, i_a[i*BCD_W +: BCD_W]} + {4'd0, w_carry};
         if (i == 0) begin
            w_dsum = w_dsum + {1'b0, i_b};
         end
         w_adj = w_dsum - 5'd10;
         if (w_dsum > 5'd9) begin
            w_raw[i*BCD_W +: BCD_W] = w_adj[3:0];
            w_carry                 = 1'b1;
         end else begin
            w_raw[i*BCD_W +: BCD_W] = w_dsum[3:0];
            w_carry                 = 1'b0;
         end
      end
   end

   assign o_sum = w_carry ? 16'h9999 : w_raw;

endmodule
`default_nettype wire

// File: rtl/game_score_timer.sv
`default_nettype none
// =====================================================================
// game_score_timer : game phase FSM, MM:SS timer and BCD score for the display
// Rev 1.0 -- optional high-score tracking enabled by `define GAME_HISCORE_EN
// =====================================================================
module game_score_timer
   import game_disp_pkg::*;
#(
   parameter int SEC_SCORE = 1,
   parameter int MAX_MIN   = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       div_clk,
   input  logic       start,
   input  logic       pause,
   input  logic       hit,
   input  logic       score_inc,
   output logic [3:0] dig7,
   output logic [3:0] dig6,
   output logic [3:0] dig5,
   output logic [3:0] dig4,
   output logic [3:0] dig3,
   output logic [3:0] dig2,
   output logic [3:0] dig1,
   output logic [3:0] dig0,
   output logic [1:0] phase,
   output logic       new_hi
);

   localparam logic [BCD_W-1:0]  c_SEC_SCORE = 4'(SEC_SCORE);
   localparam logic [BCD4_W-1:0] c_TIME_MAX  = {dec2bcd2(MAX_MIN), 8'h59};

   logic              r_div_q;
   logic              w_tick;
   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              w_clear;
   logic              w_count;
   logic              w_end;
   logic [BCD4_W-1:0] r_time;
   logic [BCD4_W-1:0] w_time_inc;
   logic [BCD4_W-1:0] r_score;
   logic [BCD4_W-1:0] w_score_sum;
   logic [BCD4_W-1:0] w_score_nxt;
   logic [BCD4_W-1:0] w_upper;
   logic [BCD_W-1:0]  w_addend;

   assign w_tick = div_clk & ~r_div_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_q <= 1'b0;
      end else begin
         r_div_q <= div_clk;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN: begin
            if (hit)        w_state_nxt = OVER;
            else if (pause) w_state_nxt = PAUSE;
         end
         PAUSE:   if (pause) w_state_nxt = RUN;
         OVER:    if (start) w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Counting only happens on RUN cycles that are not leaving RUN.
   always_comb begin
      w_clear = 1'b0;
      w_count = 1'b0;
      w_end   = 1'b0;
      case (r_state)
         IDLE:    w_clear = start;
         RUN: begin
            w_count = ~hit & ~pause;
            w_end   = hit;
         end
         OVER:    w_clear = start;
         default: ;
      endcase
   end

   always_comb begin
      w_time_inc = r_time;
      if (r_time != c_TIME_MAX) begin
         if (r_time[3:0] != 4'd9) begin
            w_time_inc[3:0] = r_time[3:0] + 4'd1;
         end else begin
            w_time_inc[3:0] = 4'd0;
            if (r_time[7:4] != 4'd5) begin
               w_time_inc[7:4] = r_time[7:4] + 4'd1;
            end else begin
               w_time_inc[7:4] = 4'd0;
               if (r_time[11:8] != 4'd9) begin
                  w_time_inc[11:8] = r_time[11:8] + 4'd1;
               end else begin
                  w_time_inc[11:8]  = 4'd0;
                  w_time_inc[15:12] = r_time[15:12] + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_time <= '0;
      end else if (w_clear) begin
         r_time <= '0;
      end else if (w_count && w_tick) begin
         r_time <= w_time_inc;
      end
   end

   assign w_addend = {3'd0, score_inc} + (w_tick ? c_SEC_SCORE : 4'd0);

   bcd_sat_add4 u_score_add (
      .i_a   (r_score),
      .i_b   (w_addend),
      .o_sum (w_score_sum)
   );

   assign w_score_nxt = w_clear ? '0 : (w_count ? w_score_sum : r_score);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_score <= '0;
      end else begin
         r_score <= w_score_nxt;
      end
   end

`ifdef GAME_HISCORE_EN
   logic [BCD4_W-1:0] r_hi;
   logic              r_new_hi;
   logic [BCD4_W-1:0] r_upper;

   // Packed BCD compares correctly as a plain unsigned number.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi     <= '0;
         r_new_hi <= 1'b0;
      end else if (w_clear) begin
         r_new_hi <= 1'b0;
      end else if (w_end && (r_score > r_hi)) begin
         r_hi     <= r_score;
         r_new_hi <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_upper <= '0;
      end else begin
         r_upper <= (w_state_nxt == IDLE) ? r_hi : w_score_nxt;
      end
   end

   assign w_upper = r_upper;
   assign new_hi  = r_new_hi;
`else
   assign w_upper = r_score;
   assign new_hi  = 1'b0;
`endif

   assign {dig7, dig6, dig5, dig4} = w_upper;
   assign {dig3, dig2, dig1, dig0} = r_time;
   assign phase                    = r_state;

endmodule
`default_nettype wire
